// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: clock rate, button channel indices, default debounce length
// and small elaboration-time sizing helpers.
package stopwatch_pkg;

    localparam int CLK_HZ           = 100_000_000;
    localparam int BTN_RST          = 0;
    localparam int BTN_PAUSE        = 1;
    localparam int BTN_SEL          = 2;
    localparam int BTN_ADJ          = 3;
    localparam int DEBOUNCE_DEFAULT = 1_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, counter debouncer and press pulse.
// Optional hold auto-repeat is built only when HOLD_REPEAT_EN is defined.
module btn_debounce_ch import stopwatch_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef HOLD_REPEAT_EN
    ,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 25_000_000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_r;
    logic          s2_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          level_prev_r;
    logic          press_r;
    logic          cnt_done_s;
    logic          level_next_s;
    logic          rise_s;
    logic          rep_fire_s;

    // Next debounced level: accept s2 only after it has disagreed for the full window.
    always_comb begin
        cnt_done_s   = (s2_r != level_r) && (cnt_r == CNT_LAST);
        rise_s       = level_r & ~level_prev_r;
        if (cnt_done_s) begin
            level_next_s = s2_r;
        end else begin
            level_next_s = level_r;
        end
    end

    // Synchronizer, debounce counter and level history.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r         <= 1'b0;
            s2_r         <= 1'b0;
            cnt_r        <= {CW{1'b0}};
            level_r      <= 1'b0;
            level_prev_r <= 1'b0;
        end else begin
            s1_r         <= raw;
            s2_r         <= s1_r;
            level_r      <= level_next_s;
            level_prev_r <= level_r;
            if ((s2_r == level_r) || cnt_done_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam int            RW          = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_r;
    logic          rep_first_r;
    logic          rep_hold_s;
    logic          rep_hit_s;

    // Repeat only while the level is high both now and after this edge, so release never pulses.
    always_comb begin
        rep_hold_s = level_next_s & level_r;
        if (rep_first_r) begin
            rep_hit_s = (rep_cnt_r == DELAY_LAST);
        end else begin
            rep_hit_s = (rep_cnt_r == PERIOD_LAST);
        end
        rep_fire_s = REPEAT_EN && rep_hold_s && rep_hit_s;
    end

    // Cycles since the last emitted pulse; reloads on every pulse so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || !rep_hold_s || !REPEAT_EN) begin
            rep_cnt_r   <= {RW{1'b0}};
            rep_first_r <= 1'b1;
        end else if (rep_fire_s) begin
            rep_cnt_r   <= {RW{1'b0}};
            rep_first_r <= 1'b0;
        end else if (press_r) begin
            rep_cnt_r   <= RW'(1);
            rep_first_r <= rep_first_r;
        end else begin
            rep_cnt_r   <= rep_cnt_r + RW'(1);
            rep_first_r <= rep_first_r;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Registered press pulse, one cycle after the debounced level rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_r <= 1'b0;
        end else begin
            press_r <= rise_s | rep_fire_s;
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/button_conditioner.sv
// Raw board buttons -> debounced levels, press pulses and the run/pause toggle.
// Define HOLD_REPEAT_EN to add hold auto-repeat on channels selected by REPEAT_MASK.
module button_conditioner import stopwatch_pkg::*; #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
`ifdef HOLD_REPEAT_EN
    parameter logic [N_BTN-1:0] REPEAT_MASK = 4'b1000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 25_000_000,
`endif
    parameter int PAUSE_IDX       = BTN_PAUSE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] raw_btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             paused
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef HOLD_REPEAT_EN
            ,
            .REPEAT_EN      (REPEAT_MASK[i] && (i != PAUSE_IDX)),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    // Run/pause state flips on each pause-button pulse; reset takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            paused <= 1'b0;
        end else begin
            paused <= paused ^ btn_press[PAUSE_IDX];
        end
    end

endmodule
